// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS controller:
// FSM states, opcode classes, opcode values and datapath select codes.
package mips_ctrl_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB
    } state_t;

    typedef enum logic [2:0] {
        C_NONE,
        C_R,
        C_LW,
        C_SW,
        C_BEQ,
        C_ADDI,
        C_J,
        C_ILL
    } op_class_t;

    localparam logic [5:0] OP_R    = 6'h00;
    localparam logic [5:0] OP_LW   = 6'h23;
    localparam logic [5:0] OP_SW   = 6'h2B;
    localparam logic [5:0] OP_BEQ  = 6'h04;
    localparam logic [5:0] OP_ADDI = 6'h08;
    localparam logic [5:0] OP_J    = 6'h02;

    localparam logic [1:0] PC_PLUS4  = 2'b00;
    localparam logic [1:0] PC_BRANCH = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    function automatic op_class_t classify(input logic [5:0] op);
        op_class_t c;
        case (op)
            OP_R:    c = C_R;
            OP_LW:   c = C_LW;
            OP_SW:   c = C_SW;
            OP_BEQ:  c = C_BEQ;
            OP_ADDI: c = C_ADDI;
            OP_J:    c = C_J;
            default: c = C_ILL;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/multicycle_control_fsm_retire_counter.sv
// Retired-instruction counter; wraps modulo 2^CNT_W.
module retire_counter #(
    parameter int CNT_W = 32
) (
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            count <= '0;
        end else if (inc) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/multicycle_control_fsm.sv
// Multicycle MIPS controller: sequences the shared datapath one
// instruction at a time and counts retired instructions.
module multicycle_control_fsm
    import mips_ctrl_pkg::*;
#(
    parameter int CNT_W   = 32,
    parameter int ALUOP_W = 2
) (
    input  logic               Clk,
    input  logic               Reset_n,
    input  logic [5:0]         Opcode,
    input  logic               Zero,
    input  logic               Mem_Ack,
    output logic               Mem_Req,
    output logic               Mem_WrEn,
    output logic               IorD_Sel,
    output logic               IR_LdEn,
    output logic               PC_LdEn,
    output logic [1:0]         PC_Sel,
    output logic               ALUSrc_Sel,
    output logic               RegDst_Sel,
    output logic               MemToReg_Sel,
    output logic               RF_WrEn,
    output logic [ALUOP_W-1:0] ALU_Op,
    output logic               Illegal_Op,
    output logic [CNT_W-1:0]   Instr_Count
);

    state_t    state_q, state_d;
    op_class_t cls_q, cls_d;
    op_class_t live_cls;
    logic      retire;
    logic [1:0] alu_op;

    assign live_cls = classify(Opcode);
    assign ALU_Op   = ALUOP_W'(alu_op);

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= S_IDLE;
            cls_q   <= C_NONE;
        end else begin
            state_q <= state_d;
            cls_q   <= cls_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        cls_d        = cls_q;
        retire       = 1'b0;
        Mem_Req      = 1'b0;
        Mem_WrEn     = 1'b0;
        IorD_Sel     = 1'b0;
        IR_LdEn      = 1'b0;
        PC_LdEn      = 1'b0;
        PC_Sel       = PC_PLUS4;
        ALUSrc_Sel   = 1'b0;
        RegDst_Sel   = 1'b0;
        MemToReg_Sel = 1'b0;
        RF_WrEn      = 1'b0;
        alu_op       = ALU_ADD;
        Illegal_Op   = 1'b0;

        unique case (state_q)
            S_IDLE: state_d = S_FETCH;

            S_FETCH: begin
                Mem_Req = 1'b1;
                if (Mem_Ack) begin
                    IR_LdEn = 1'b1;
                    PC_LdEn = 1'b1;
                    state_d = S_DECODE;
                end
            end

            // IR is valid here, so the live opcode picks the path
            S_DECODE: begin
                cls_d = live_cls;
                case (live_cls)
                    C_ILL: begin
                        Illegal_Op = 1'b1;
                        state_d    = S_FETCH;
                    end
                    C_J: begin
                        PC_LdEn = 1'b1;
                        PC_Sel  = PC_JUMP;
                        retire  = 1'b1;
                        state_d = S_FETCH;
                    end
                    default: state_d = S_EXEC;
                endcase
            end

            S_EXEC: begin
                case (cls_q)
                    C_R: begin
                        alu_op  = ALU_FUNCT;
                        state_d = S_WB;
                    end
                    C_ADDI: begin
                        ALUSrc_Sel = 1'b1;
                        state_d    = S_WB;
                    end
                    C_LW, C_SW: begin
                        ALUSrc_Sel = 1'b1;
                        state_d    = S_MEM;
                    end
                    C_BEQ: begin
                        alu_op  = ALU_SUB;
                        PC_LdEn = Zero;
                        PC_Sel  = PC_BRANCH;
                        retire  = 1'b1;
                        state_d = S_FETCH;
                    end
                    default: state_d = S_FETCH;
                endcase
            end

            S_MEM: begin
                Mem_Req  = 1'b1;
                IorD_Sel = 1'b1;
                Mem_WrEn = (cls_q == C_SW);
                if (Mem_Ack) begin
                    if (cls_q == C_SW) begin
                        retire  = 1'b1;
                        state_d = S_FETCH;
                    end else begin
                        state_d = S_WB;
                    end
                end
            end

            S_WB: begin
                RF_WrEn      = 1'b1;
                RegDst_Sel   = (cls_q == C_R);
                MemToReg_Sel = (cls_q == C_LW);
                retire       = 1'b1;
                state_d      = S_FETCH;
            end

            default: state_d = S_IDLE;
        endcase
    end

    retire_counter #(
        .CNT_W (CNT_W)
    ) u_retire (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .inc     (retire),
        .count   (Instr_Count)
    );

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Directed bench for multicycle_control_fsm with a 4-bit counter
// so the retire count wrap is reachable.
module tb_multicycle_control_fsm;

    logic       Clk = 1'b0;
    logic       Reset_n;
    logic [5:0] Opcode;
    logic       Zero;
    logic       Mem_Ack;
    logic       Mem_Req, Mem_WrEn, IorD_Sel, IR_LdEn, PC_LdEn;
    logic [1:0] PC_Sel;
    logic       ALUSrc_Sel, RegDst_Sel, MemToReg_Sel, RF_WrEn;
    logic [1:0] ALU_Op;
    logic       Illegal_Op;
    logic [3:0] Instr_Count;
    logic [13:0] outs;

    int passed = 0;
    int total  = 0;

    always #5 Clk = ~Clk;

    multicycle_control_fsm #(.CNT_W(4), .ALUOP_W(2)) dut (
        .Clk          (Clk),
        .Reset_n      (Reset_n),
        .Opcode       (Opcode),
        .Zero         (Zero),
        .Mem_Ack      (Mem_Ack),
        .Mem_Req      (Mem_Req),
        .Mem_WrEn     (Mem_WrEn),
        .IorD_Sel     (IorD_Sel),
        .IR_LdEn      (IR_LdEn),
        .PC_LdEn      (PC_LdEn),
        .PC_Sel       (PC_Sel),
        .ALUSrc_Sel   (ALUSrc_Sel),
        .RegDst_Sel   (RegDst_Sel),
        .MemToReg_Sel (MemToReg_Sel),
        .RF_WrEn      (RF_WrEn),
        .ALU_Op       (ALU_Op),
        .Illegal_Op   (Illegal_Op),
        .Instr_Count  (Instr_Count)
    );

    assign outs = {Mem_Req, Mem_WrEn, IorD_Sel, IR_LdEn, PC_LdEn,
                   PC_Sel, ALUSrc_Sel, RegDst_Sel, MemToReg_Sel,
                   RF_WrEn, ALU_Op, Illegal_Op};

    function automatic logic [13:0] mk(
        input logic req, wr, iord, ir, pcld,
        input logic [1:0] pcsel,
        input logic alusrc, regdst, m2r, rfwr,
        input logic [1:0] aluop,
        input logic ill
    );
        return {req, wr, iord, ir, pcld, pcsel,
                alusrc, regdst, m2r, rfwr, aluop, ill};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic chk_out(input string tag, input logic [13:0] exp);
        #1;
        chk(tag, 32'(outs), 32'(exp));
    endtask

    task automatic tick;
        @(posedge Clk);
        #1;
    endtask

    localparam logic [13:0] NONE = 14'd0;

    initial begin
        Reset_n = 1'b0;
        Opcode  = 6'h00;
        Zero    = 1'b0;
        Mem_Ack = 1'b1;
        #3;
        chk("reset_outs", 32'(outs), 32'(NONE));
        chk("reset_cnt", 32'(Instr_Count), 32'd0);
        tick;
        Reset_n = 1'b1;
        chk_out("idle", NONE);
        tick;

        // R-type, zero-wait memory
        chk_out("r_fetch", mk(1,0,0,1,1,2'b00,0,0,0,0,2'b00,0));
        tick;
        chk_out("r_decode", NONE);
        tick;
        Opcode = 6'h23;
        chk_out("r_exec", mk(0,0,0,0,0,2'b00,0,0,0,0,2'b10,0));
        tick;
        chk_out("r_wb", mk(0,0,0,0,0,2'b00,0,1,0,1,2'b00,0));
        chk("r_cnt_before", 32'(Instr_Count), 32'd0);
        tick;
        chk("r_cnt_after", 32'(Instr_Count), 32'd1);

        // lw with two wait cycles in MEM
        chk_out("lw_fetch", mk(1,0,0,1,1,2'b00,0,0,0,0,2'b00,0));
        tick;
        chk_out("lw_decode", NONE);
        tick;
        chk_out("lw_exec", mk(0,0,0,0,0,2'b00,1,0,0,0,2'b00,0));
        tick;
        Mem_Ack = 1'b0;
        chk_out("lw_mem_w1", mk(1,0,1,0,0,2'b00,0,0,0,0,2'b00,0));
        tick;
        chk_out("lw_mem_w2", mk(1,0,1,0,0,2'b00,0,0,0,0,2'b00,0));
        tick;
        Mem_Ack = 1'b1;
        chk_out("lw_mem_ack", mk(1,0,1,0,0,2'b00,0,0,0,0,2'b00,0));
        tick;
        chk_out("lw_wb", mk(0,0,0,0,0,2'b00,0,0,1,1,2'b00,0));
        tick;
        chk("lw_cnt", 32'(Instr_Count), 32'd2);

        // beq taken, with one fetch wait cycle
        Opcode  = 6'h04;
        Zero    = 1'b1;
        Mem_Ack = 1'b0;
        chk_out("beq_fetch_wait", mk(1,0,0,0,0,2'b00,0,0,0,0,2'b00,0));
        tick;
        Mem_Ack = 1'b1;
        chk_out("beq_fetch", mk(1,0,0,1,1,2'b00,0,0,0,0,2'b00,0));
        tick;
        chk_out("beq_decode", NONE);
        tick;
        chk_out("beq_exec_z1", mk(0,0,0,0,1,2'b01,0,0,0,0,2'b01,0));
        tick;
        chk("beq_cnt1", 32'(Instr_Count), 32'd3);

        // beq not taken
        Zero = 1'b0;
        tick;
        tick;
        chk_out("beq_exec_z0", mk(0,0,0,0,0,2'b01,0,0,0,0,2'b01,0));
        tick;
        chk("beq_cnt2", 32'(Instr_Count), 32'd4);

        // illegal opcode
        Opcode = 6'h3F;
        tick;
        chk_out("ill_decode", mk(0,0,0,0,0,2'b00,0,0,0,0,2'b00,1));
        tick;
        chk_out("ill_back_fetch", mk(1,0,0,1,1,2'b00,0,0,0,0,2'b00,0));
        chk("ill_cnt", 32'(Instr_Count), 32'd4);

        // sw interrupted by reset while waiting in MEM
        Opcode = 6'h2B;
        tick;
        tick;
        chk_out("sw_exec", mk(0,0,0,0,0,2'b00,1,0,0,0,2'b00,0));
        tick;
        Mem_Ack = 1'b0;
        chk_out("sw_mem", mk(1,1,1,0,0,2'b00,0,0,0,0,2'b00,0));
        Reset_n = 1'b0;
        chk_out("sw_reset_outs", NONE);
        chk("sw_reset_cnt", 32'(Instr_Count), 32'd0);
        tick;
        Reset_n = 1'b1;
        Mem_Ack = 1'b1;
        chk_out("post_reset_idle", NONE);
        tick;

        // 16 jumps walk the 4-bit counter through its wrap
        Opcode = 6'h02;
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("j%0d_cnt", i), 32'(Instr_Count), 32'(i));
            tick;
            if (i == 0)
                chk_out("j_decode", mk(0,0,0,0,1,2'b10,0,0,0,0,2'b00,0));
            tick;
        end
        chk("j_wrap_cnt", 32'(Instr_Count), 32'd0);
        chk_out("j_wrap_fetch", mk(1,0,0,1,1,2'b00,0,0,0,0,2'b00,0));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
